jtag_dbg_cmd_sequencer: RTL and testbench
=========================================

JTAG_DBG_CMD_SEQUENCER -- requirements
Module: jtag_dbg_cmd_sequencer

Interface
REQ-001 Parameter ADDR_W, default 9: OCI memory word-address width.
REQ-002 Parameter FIFO_DEPTH, default 4 (power of two, 2..16): command queue depth.
REQ-003 clk  in  1  the only clock; all logic rising-edge on clk.
REQ-004 reset_n  in  1  reset, synchronous, active-low.
REQ-005 cmd_valid  in  1  one-cycle pulse: an update-DR event, already synchronized to clk.
REQ-006 cmd_ir  in  2  instruction code latched with the command.
REQ-007 cmd_data  in  38  shifted data word latched with the command.
REQ-008 mem_address  out  ADDR_W  OCI memory word address.
REQ-009 mem_read / mem_write  out  1 each  access strobes, mutually exclusive.
REQ-010 mem_writedata  out  32  write data.
REQ-011 mem_waitrequest  in  1  stall; an access completes in the first cycle it is low.
REQ-012 mem_readdata  in  32  read data, valid in the completing cycle.
REQ-013 rd_data  out  32  last read result (MonDReg image); rd_valid  out  1  one-cycle pulse when rd_data updates.
REQ-014 brk_wr  out  1  one-cycle pulse; brk_sel  out  2; brk_data  out  32: break-register write port.
REQ-015 busy  out  1  high while the queue is non-empty or an access is in flight.
REQ-016 ovf_err  out  1  sticky: command dropped; tmo_err  out  1  sticky: access timed out.

Function
REQ-017 Every cmd_valid pushes {cmd_ir, cmd_data} into the FIFO; full and no pop in the same cycle -> command dropped, ovf_err set.
REQ-018 Push into a full FIFO is accepted when a pop occurs in the same cycle.
REQ-019 FSM states IDLE, DECODE, ACCESS; IDLE -> DECODE when FIFO is non-empty; DECODE pops one entry.
REQ-020 ir=00, data[37:36]=01 (set-address): addr <= data[ADDR_W-1:0]; return to IDLE; no bus activity.
REQ-021 ir=00, data[37:36]=10 (write): enter ACCESS with mem_write=1, mem_address=addr, mem_writedata=data[31:0].
REQ-022 ir=00, data[37:36]=11 (read): enter ACCESS with mem_read=1, mem_address=addr.
REQ-023 ir=00, data[37:36]=00: no-op; return to IDLE.
REQ-024 In ACCESS, strobe, address and data hold stable while mem_waitrequest=1.
REQ-025 ACCESS completion: strobe drops the next cycle; addr increments by 1, wrapping 2^ADDR_W-1 -> 0; FSM returns to IDLE.
REQ-026 Read completion: rd_data <= mem_readdata and rd_valid pulses in the cycle after completion.
REQ-027 ir=10: brk_wr pulses one cycle with brk_sel=data[37:36], brk_data=data[31:0]; return to IDLE.
REQ-028 ir=01: discarded; return to IDLE.
REQ-029 ir=11 abort: clears ovf_err and tmo_err and flushes remaining FIFO entries; an in-flight access is not affected, because abort is only decoded from IDLE.
REQ-030 Minimum latency from cmd_valid into an empty FIFO to strobe assertion: 3 clk cycles.
REQ-031 A cmd_valid arriving while an access is in flight is queued, never lost unless the FIFO is full.

Reset
REQ-032 With reset_n low at a clk edge: FSM=IDLE, FIFO empty, addr=0, all strobes/pulses=0, rd_data=0, brk_sel=0, brk_data=0, mem_writedata=0, busy=0, ovf_err=0, tmo_err=0.
REQ-033 Reset during ACCESS drops the strobe at the same edge; the interrupted access is not retried.

Configuration
REQ-034 Macro JTAG_DBG_SEQ_TIMEOUT_EN defined: an 8-bit counter runs in ACCESS.
REQ-035 With the macro defined, 255 consecutive cycles with mem_waitrequest=1 force strobe low, set tmo_err, leave addr unchanged, return to IDLE, and give no rd_valid.
REQ-036 Macro undefined: ACCESS waits indefinitely; tmo_err is tied to 0.

Verification
REQ-037 Set-address 0x010, write 0xDEADBEEF, read, waitrequest=0 -> write at 0x010, then read at 0x011; rd_valid pulses once with readdata.
REQ-038 Set-address 0x1FF, two writes -> accesses at 0x1FF then 0x000 (wrap).
REQ-039 Hold waitrequest=1 for 10 cycles; issue 5 cmd_valid -> 4 queued, ovf_err=1, mem_address and data stable throughout.
REQ-040 Full FIFO, cmd_valid coincident with a DECODE pop -> accepted, ovf_err stays 0.
REQ-041 ir=10, data={2'b10, 4'h0, 32'h12345678} -> brk_wr one cycle with brk_sel=2 and brk_data=0x12345678; then ir=11 -> ovf_err=0, FIFO empty.
REQ-042 TIMEOUT_EN, waitrequest stuck at 1 -> strobe drops after 255 cycles, tmo_err=1; reset_n low mid-access -> all outputs at their reset values next edge.

Source files
------------

// File: rtl/jtag_dbg_cmd_sequencer_if.sv
// Bus bundle for jtag_dbg_cmd_sequencer: command push from the JTAG side,
// OCI memory port, read-result port, break-register port and status.
//
// Handshakes: cmd_valid is a one-cycle push with no ready; the sequencer
// either queues the command or drops it and raises ovf_err. A memory access
// is a valid/ready pair where mem_read/mem_write is valid and
// !mem_waitrequest is ready: the access completes in the first cycle in which
// both hold, and until then strobe, address and write data stay stable.
interface jtag_dbg_cmd_sequencer_if #(
  parameter int ADDR_W = 9
);
  logic              cmd_valid;
  logic [1:0]        cmd_ir;
  logic [37:0]       cmd_data;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_writedata;
  logic              mem_waitrequest;
  logic [31:0]       mem_readdata;
  logic [31:0]       rd_data;
  logic              rd_valid;
  logic              brk_wr;
  logic [1:0]        brk_sel;
  logic [31:0]       brk_data;
  logic              busy;
  logic              ovf_err;
  logic              tmo_err;

  // Sequencer side.
  modport master (
    input  cmd_valid, cmd_ir, cmd_data, mem_waitrequest, mem_readdata,
    output mem_address, mem_read, mem_write, mem_writedata,
           rd_data, rd_valid, brk_wr, brk_sel, brk_data,
           busy, ovf_err, tmo_err
  );

  // Host / memory side.
  modport slave (
    output cmd_valid, cmd_ir, cmd_data, mem_waitrequest, mem_readdata,
    input  mem_address, mem_read, mem_write, mem_writedata,
           rd_data, rd_valid, brk_wr, brk_sel, brk_data,
           busy, ovf_err, tmo_err
  );
endinterface

// File: rtl/jtag_dbg_cmd_sequencer.sv
// JTAG debug command sequencer: queues update-DR commands in a small FIFO and
// turns them into OCI memory accesses, break-register writes or aborts.
// Optional macro JTAG_DBG_SEQ_TIMEOUT_EN: abandons an access after 255
// consecutive stalled cycles and flags tmo_err; otherwise ACCESS waits forever.
// ADDR_W must not exceed 32 (the address is taken from the data payload).
module jtag_dbg_cmd_sequencer #(
  parameter int ADDR_W     = 9,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  jtag_dbg_cmd_sequencer_if.master bus,
  output logic [1:0]               o_dbg_state
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t r_state, w_next_state;

  // Entry layout: {ir[1:0], op[1:0], payload[31:0]}; data[35:32] carries nothing.
  logic [35:0]       r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr, r_wr_ptr;
  logic [CNT_W-1:0]  r_count;

  logic [ADDR_W-1:0] r_addr;
  logic              r_op_wr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rd_data;
  logic              r_rd_valid;
  logic              r_brk_wr;
  logic [1:0]        r_brk_sel;
  logic [31:0]       r_brk_data;
  logic              r_ovf_err;

  logic        w_empty, w_full, w_pop, w_push_ok, w_drop;
  logic [35:0] w_head;
  logic [1:0]  w_ir, w_op;
  logic        w_set_addr, w_start_wr, w_start_rd, w_brk, w_abort, w_done, w_tmo;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_head    = r_fifo[r_rd_ptr];
  assign w_ir      = w_head[35:34];
  assign w_op      = w_head[33:32];
  // A push into a full queue still fits when the head leaves in the same cycle.
  assign w_push_ok = bus.cmd_valid && (!w_full || w_pop);
  assign w_drop    = bus.cmd_valid && w_full && !w_pop;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  // Next state and one-cycle decode controls; DECODE always pops the head.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_set_addr   = 1'b0;
    w_start_wr   = 1'b0;
    w_start_rd   = 1'b0;
    w_brk        = 1'b0;
    w_abort      = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) w_next_state = ST_DECODE;
      end
      ST_DECODE: begin
        w_pop        = 1'b1;
        w_next_state = ST_IDLE;
        case (w_ir)
          2'b00: begin
            case (w_op)
              2'b01: w_set_addr = 1'b1;
              2'b10: begin
                w_start_wr   = 1'b1;
                w_next_state = ST_ACCESS;
              end
              2'b11: begin
                w_start_rd   = 1'b1;
                w_next_state = ST_ACCESS;
              end
              default: ;
            endcase
          end
          2'b10:   w_brk   = 1'b1;
          2'b11:   w_abort = 1'b1;
          default: ;
        endcase
      end
      ST_ACCESS: begin
        if (!bus.mem_waitrequest) begin
          w_done       = 1'b1;
          w_next_state = ST_IDLE;
        end else if (w_tmo) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Queue storage; no reset needed, occupancy is tracked by r_count.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_fifo[r_wr_ptr] <= {bus.cmd_ir, bus.cmd_data[37:36], bus.cmd_data[31:0]};
  end

  // Queue pointers and occupancy; abort discards everything behind its own entry.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (w_abort) begin
      r_rd_ptr <= r_wr_ptr;
      r_wr_ptr <= w_push_ok ? r_wr_ptr + 1'b1 : r_wr_ptr;
      r_count  <= w_push_ok ? CNT_W'(1) : '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  // Address pointer, access setup and read-result capture.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_addr     <= '0;
      r_op_wr    <= 1'b0;
      r_wdata    <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      if (w_set_addr) r_addr <= w_head[ADDR_W-1:0];
      if (w_start_wr) begin
        r_op_wr <= 1'b1;
        r_wdata <= w_head[31:0];
      end
      if (w_start_rd) r_op_wr <= 1'b0;
      if (w_done) begin
        r_addr <= r_addr + 1'b1;
        if (!r_op_wr) begin
          r_rd_data  <= bus.mem_readdata;
          r_rd_valid <= 1'b1;
        end
      end
    end
  end

  // Break-register write port and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_brk_wr   <= 1'b0;
      r_brk_sel  <= '0;
      r_brk_data <= '0;
      r_ovf_err  <= 1'b0;
    end else begin
      r_brk_wr <= w_brk;
      if (w_brk) begin
        r_brk_sel  <= w_op;
        r_brk_data <= w_head[31:0];
      end
      if (w_abort)     r_ovf_err <= 1'b0;
      else if (w_drop) r_ovf_err <= 1'b1;
    end
  end

`ifdef JTAG_DBG_SEQ_TIMEOUT_EN
  logic [7:0] r_tmo_cnt;
  logic       r_tmo_err;

  // The 255th stalled cycle in ACCESS is the one that ends the access.
  assign w_tmo = (r_state == ST_ACCESS) && bus.mem_waitrequest && (r_tmo_cnt == 8'd254);

  // Stall counter, cleared whenever no access is in flight.
  always_ff @(posedge clk) begin
    if (!reset_n || r_state != ST_ACCESS) r_tmo_cnt <= '0;
    else if (bus.mem_waitrequest)         r_tmo_cnt <= r_tmo_cnt + 1'b1;
  end

  // Sticky timeout flag, cleared by abort.
  always_ff @(posedge clk) begin
    if (!reset_n)     r_tmo_err <= 1'b0;
    else if (w_abort) r_tmo_err <= 1'b0;
    else if (w_tmo)   r_tmo_err <= 1'b1;
  end

  assign bus.tmo_err = r_tmo_err;
`else
  assign w_tmo       = 1'b0;
  assign bus.tmo_err = 1'b0;
`endif

  assign bus.mem_address   = r_addr;
  assign bus.mem_write     = (r_state == ST_ACCESS) && r_op_wr;
  assign bus.mem_read      = (r_state == ST_ACCESS) && !r_op_wr;
  assign bus.mem_writedata = r_wdata;
  assign bus.rd_data       = r_rd_data;
  assign bus.rd_valid      = r_rd_valid;
  assign bus.brk_wr        = r_brk_wr;
  assign bus.brk_sel       = r_brk_sel;
  assign bus.brk_data      = r_brk_data;
  assign bus.busy          = !w_empty || (r_state != ST_IDLE);
  assign bus.ovf_err       = r_ovf_err;
  assign o_dbg_state       = r_state;
endmodule

// File: tb/tb_jtag_dbg_cmd_sequencer.sv
// Directed bench for jtag_dbg_cmd_sequencer. Inputs change 1 ns after the
// rising edge; outputs are checked there or at the falling edge. A monitor
// matches every completed bus access against exp_q.
module tb_jtag_dbg_cmd_sequencer;
  localparam int ADDR_W = 9;
  localparam int SB_W   = 1 + ADDR_W + 32;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;
  int pulses;
  logic [SB_W-1:0] exp_q[$];
  logic [SB_W-1:0] mon_obs;
  logic [SB_W-1:0] mon_exp;

  jtag_dbg_cmd_sequencer_if #(.ADDR_W(ADDR_W)) bus_if ();

  jtag_dbg_cmd_sequencer #(.ADDR_W(ADDR_W), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus_if),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string p);
    check({p, "_mem_read"},  bus_if.mem_read, 0);
    check({p, "_mem_write"}, bus_if.mem_write, 0);
    check({p, "_mem_addr"},  bus_if.mem_address, 0);
    check({p, "_mem_wdata"}, bus_if.mem_writedata, 0);
    check({p, "_rd"},        {bus_if.rd_valid, bus_if.rd_data}, 0);
    check({p, "_brk"},       {bus_if.brk_wr, bus_if.brk_sel, bus_if.brk_data}, 0);
    check({p, "_status"},    {bus_if.busy, bus_if.ovf_err, bus_if.tmo_err}, 0);
    check({p, "_state"},     dbg_state, 0);
  endtask

  // Scoreboard: every completing access must be the next expected one.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && (bus_if.mem_read || bus_if.mem_write) && !bus_if.mem_waitrequest) begin
      mon_obs = {bus_if.mem_write, bus_if.mem_address,
                 bus_if.mem_write ? bus_if.mem_writedata : 32'h0};
      check("strobe_excl", bus_if.mem_read & bus_if.mem_write, 0);
      check("txn_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        check("bus_txn", mon_obs, mon_exp);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] ir, input logic [37:0] data);
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_ir    = ir;
    bus_if.cmd_data  = data;
    tick();
    bus_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_strobe(input string tag);
    for (int i = 0; i < 10; i++) begin
      if (bus_if.mem_read || bus_if.mem_write) break;
      tick();
    end
    check(tag, bus_if.mem_read | bus_if.mem_write, 1);
  endtask

  task automatic exp_wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    exp_q.push_back({1'b1, a, d});
  endtask

  task automatic exp_rd(input logic [ADDR_W-1:0] a);
    exp_q.push_back({1'b0, a, 32'h0});
  endtask

  function automatic logic [37:0] d_setaddr(input logic [ADDR_W-1:0] a);
    return {2'b01, 36'(a)};
  endfunction

  function automatic logic [37:0] d_write(input logic [31:0] d);
    return {2'b10, 4'h0, d};
  endfunction

  function automatic logic [37:0] d_read();
    return {2'b11, 36'h0};
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    reset_n                = 1'b0;
    bus_if.cmd_valid       = 1'b0;
    bus_if.cmd_ir          = 2'b00;
    bus_if.cmd_data        = '0;
    bus_if.mem_waitrequest = 1'b0;
    bus_if.mem_readdata    = '0;
    repeat (3) tick();
    check_reset("rst");
    reset_n = 1'b1;
    tick();

    // Latency: command sampled at edge 1, strobe visible after edge 3.
    exp_wr(9'h000, 32'h0000_0011);
    send_cmd(2'b00, d_write(32'h0000_0011));
    check("lat_busy", bus_if.busy, 1);
    tick();
    check("lat_e2_idle", bus_if.mem_write, 0);
    tick();
    check("lat_e3_strobe", {bus_if.mem_write, bus_if.mem_address}, {1'b1, 9'h000});
    tick();
    check("lat_strobe_drop", bus_if.mem_write, 0);
    repeat (3) tick();

    // Set-address, write, read back-to-back.
    bus_if.mem_readdata = 32'hCAFE_F00D;
    exp_wr(9'h010, 32'hDEAD_BEEF);
    exp_rd(9'h011);
    send_cmd(2'b00, d_setaddr(9'h010));
    send_cmd(2'b00, d_write(32'hDEAD_BEEF));
    send_cmd(2'b00, d_read());
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus_if.rd_valid) begin
        pulses++;
        check("rd_data", bus_if.rd_data, 32'hCAFE_F00D);
      end
    end
    check("rd_valid_pulses", pulses, 1);
    check("addr_after_rw", bus_if.mem_address, 9'h012);
    check("idle_not_busy", bus_if.busy, 0);

    // Address wrap.
    exp_wr(9'h1FF, 32'hAAAA_5555);
    exp_wr(9'h000, 32'h1234_0001);
    send_cmd(2'b00, d_setaddr(9'h1FF));
    send_cmd(2'b00, d_write(32'hAAAA_5555));
    send_cmd(2'b00, d_write(32'h1234_0001));
    repeat (30) tick();
    check("addr_after_wrap", bus_if.mem_address, 9'h001);

    // Stall with 5 commands arriving: 4 queued, 1 dropped, bus stable.
    bus_if.mem_waitrequest = 1'b1;
    exp_wr(9'h001, 32'h0BAD_F00D);
    for (int i = 0; i < 4; i++) exp_wr(9'(2 + i), 32'h100 + i);
    send_cmd(2'b00, d_write(32'h0BAD_F00D));
    wait_strobe("stall_start");
    for (int i = 0; i < 10; i++) begin
      bus_if.cmd_valid = (i < 5);
      bus_if.cmd_ir    = 2'b00;
      bus_if.cmd_data  = d_write(32'h100 + i);
      tick();
      check("stall_stable", {bus_if.mem_write, bus_if.mem_read, bus_if.mem_address, bus_if.mem_writedata},
            {1'b1, 1'b0, 9'h001, 32'h0BAD_F00D});
    end
    bus_if.cmd_valid = 1'b0;
    check("stall_ovf", {bus_if.ovf_err, bus_if.busy}, 2'b11);
    bus_if.mem_waitrequest = 1'b0;
    repeat (40) tick();
    check("stall_drain_addr", bus_if.mem_address, 9'h006);
    check("ovf_sticky", {bus_if.ovf_err, bus_if.busy}, 2'b10);

    // Abort clears ovf_err; then push into a full queue on the pop cycle.
    send_cmd(2'b11, 38'h0);
    repeat (4) tick();
    check("abort_clr_ovf", bus_if.ovf_err, 0);
    bus_if.mem_waitrequest = 1'b1;
    exp_wr(9'h006, 32'h0000_0077);
    send_cmd(2'b00, d_write(32'h0000_0077));
    wait_strobe("full_start");
    send_cmd(2'b00, 38'h0);
    send_cmd(2'b00, 38'h0);
    send_cmd(2'b00, 38'h0);
    send_cmd(2'b00, d_setaddr(9'h0A0));
    check("full_no_ovf", bus_if.ovf_err, 0);
    bus_if.mem_waitrequest = 1'b0;
    tick();
    tick();
    check("full_decode_state", dbg_state, 2'd1);
    exp_wr(9'h0A0, 32'h55AA_55AA);
    send_cmd(2'b00, d_write(32'h55AA_55AA));
    check("push_on_pop_no_ovf", bus_if.ovf_err, 0);
    repeat (40) tick();
    check("push_on_pop_addr", {bus_if.ovf_err, bus_if.mem_address}, {1'b0, 9'h0A1});

    // Break-register write, then a discarded ir=01 command.
    send_cmd(2'b10, {2'b10, 4'h0, 32'h1234_5678});
    tick();
    check("brk_not_yet", bus_if.brk_wr, 0);
    tick();
    check("brk_pulse", {bus_if.brk_wr, bus_if.brk_sel, bus_if.brk_data}, {1'b1, 2'd2, 32'h1234_5678});
    tick();
    check("brk_one_cycle", bus_if.brk_wr, 0);
    send_cmd(2'b01, d_write(32'h0000_00EE));
    repeat (5) tick();
    check("ir01_discard", {bus_if.busy, bus_if.mem_address}, {1'b0, 9'h0A1});

    // Abort flushes queued work behind it but not the access in flight.
    bus_if.mem_waitrequest = 1'b1;
    exp_wr(9'h0A1, 32'h0000_0099);
    send_cmd(2'b00, d_write(32'h0000_0099));
    wait_strobe("flush_start");
    send_cmd(2'b11, 38'h0);
    send_cmd(2'b00, d_write(32'h1));
    send_cmd(2'b00, d_write(32'h2));
    send_cmd(2'b00, d_write(32'h3));
    send_cmd(2'b00, d_write(32'h4));
    check("flush_ovf_set", bus_if.ovf_err, 1);
    bus_if.mem_waitrequest = 1'b0;
    repeat (30) tick();
    check("flush_status", {bus_if.ovf_err, bus_if.busy, dbg_state}, {1'b0, 1'b0, 2'd0});
    check("flush_addr", bus_if.mem_address, 9'h0A2);

    // Stuck waitrequest.
    bus_if.mem_waitrequest = 1'b1;
    send_cmd(2'b00, d_write(32'h0000_0005));
    wait_strobe("stuck_start");
    repeat (254) tick();
    check("stuck_254", bus_if.mem_write, 1);
    tick();
`ifdef JTAG_DBG_SEQ_TIMEOUT_EN
    check("tmo_strobe_drop", {bus_if.mem_write, bus_if.tmo_err, bus_if.rd_valid}, 3'b010);
    check("tmo_addr_kept", bus_if.mem_address, 9'h0A2);
    tick();
    check("tmo_idle", {dbg_state, bus_if.tmo_err}, {2'd0, 1'b1});
    send_cmd(2'b00, d_write(32'h0000_0006));
    wait_strobe("tmo_restart");
`else
    check("no_tmo_waiting", {bus_if.mem_write, bus_if.tmo_err}, 2'b10);
`endif

    // Reset in the middle of an access with a command queued behind it.
    send_cmd(2'b00, 38'h0);
    reset_n = 1'b0;
    tick();
    check_reset("rst_mid");
    reset_n = 1'b1;
    bus_if.mem_waitrequest = 1'b0;
    bus_if.mem_readdata    = 32'h1357_2468;
    repeat (5) tick();
    check("post_rst_quiet", {bus_if.busy, bus_if.mem_address}, {1'b0, 9'h000});
    exp_rd(9'h033);
    send_cmd(2'b00, d_setaddr(9'h033));
    send_cmd(2'b00, d_read());
    repeat (20) tick();
    check("post_rst_read", {bus_if.rd_data, bus_if.mem_address}, {32'h1357_2468, 9'h034});

    check("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
